// File: rtl/regset_write_arbiter_pkg.sv
// Shared types for the register-set write arbiter.
//   word     : architectural data word
//   regnum   : register index, wide enough for REGISTER_COUNT-1
//   wb_req_t : writeback request payload (destination + data)
package regset_write_arbiter_pkg;

  localparam int REGISTER_COUNT = 32;
  localparam int WORD_W         = 32;
  localparam int REGNUM_W       = $clog2(REGISTER_COUNT);

  typedef logic [WORD_W-1:0]   word;
  typedef logic [REGNUM_W-1:0] regnum;

  typedef struct packed {
    regnum rd;
    word   data;
  } wb_req_t;

endpackage

// File: rtl/regset_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, res : clock, asynchronous active-low reset
//   req      : request vector, bit 0 is favoured after reset
//   advance  : arbitration enabled this cycle (no grant when low)
//   grant    : one-hot grant, combinational from req/advance/pointer
// The pointer flips only when both sides request and a grant is issued,
// so an uncontended requester never costs the other side its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_r;

  // Grant selection: single requester wins outright, contention uses the pointer
  always_comb begin
    grant = 2'b00;
    if (!advance) begin
      grant = 2'b00;
    end else if (req == 2'b11) begin
      grant = ptr_r ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // Pointer update on contended grants only
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ptr_r <= 1'b0;
    end else if (advance && (req == 2'b11)) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/regset_write_arbiter.sv
// Shares the register set's single write port between the load writeback,
// the ALU writeback and an internal clear sequencer.
//   clk, res              : clock, asynchronous active-low reset
//   ld_*  / alu_*         : valid/ready writeback requesters (ready is combinational)
//   clear_start           : pulse starting a clear of x1..x(RegisterCount-1)
//   clear_busy/clear_done : registered; high while a clear write is on the outputs,
//                           done marks the last clear write
//   write/write_reg/write_enable : registered register-set write port
module regset_write_arbiter
  import regset_write_arbiter_pkg::*;
#(
  parameter int RegisterCount = REGISTER_COUNT
) (
  input  logic  clk,
  input  logic  res,
  input  logic  ld_valid,
  output logic  ld_ready,
  input  regnum ld_reg,
  input  word   ld_data,
  input  logic  alu_valid,
  output logic  alu_ready,
  input  regnum alu_reg,
  input  word   alu_data,
  input  logic  clear_start,
  output logic  clear_busy,
  output logic  clear_done,
  output word   write,
  output regnum write_reg,
  output logic  write_enable
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam regnum FIRST_IDX = regnum'(1);
  localparam regnum LAST_IDX  = regnum'(RegisterCount - 1);

  state_t  state_r, state_nx;
  regnum   idx_r, idx_nx;
  word     write_r, write_nx;
  regnum   write_reg_r, write_reg_nx;
  logic    write_enable_r, write_enable_nx;
  logic    clear_busy_r, clear_busy_nx;
  logic    clear_done_r, clear_done_nx;

  logic       arb_enable_s;
  logic       clear_step_s;
  logic [1:0] grant_s;
  wb_req_t    ld_req_s, alu_req_s, win_req_s;

  assign ld_req_s  = '{rd: ld_reg,  data: ld_data};
  assign alu_req_s = '{rd: alu_reg, data: alu_data};

  // A clear_start cycle is spent launching the clear, so nobody is granted
  assign arb_enable_s = (state_r == ST_ARB) && !clear_start;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .res     (res),
    .req     ({alu_valid, ld_valid}),
    .advance (arb_enable_s),
    .grant   (grant_s)
  );

  assign ld_ready  = grant_s[0];
  assign alu_ready = grant_s[1];
  assign win_req_s = grant_s[1] ? alu_req_s : ld_req_s;

  // Next-state and next-output computation
  always_comb begin
    state_nx        = state_r;
    idx_nx          = idx_r;
    write_nx        = write_r;
    write_reg_nx    = write_reg_r;
    write_enable_nx = 1'b0;
    clear_busy_nx   = 1'b0;
    clear_done_nx   = 1'b0;
    clear_step_s    = 1'b0;

    case (state_r)
      ST_ARB: begin
        if (clear_start) begin
          // The first clear write is issued in the start cycle itself
          clear_step_s = 1'b1;
        end else if (grant_s != 2'b00) begin
          write_nx        = win_req_s.data;
          write_reg_nx    = win_req_s.rd;
          write_enable_nx = (win_req_s.rd != regnum'(0));
        end else begin
          write_enable_nx = 1'b0;
        end
      end
      ST_CLEAR: begin
        clear_step_s = 1'b1;
      end
      default: begin
        state_nx = ST_ARB;
      end
    endcase

    if (clear_step_s) begin
      write_nx        = word'(0);
      write_reg_nx    = idx_r;
      write_enable_nx = 1'b1;
      clear_busy_nx   = 1'b1;
      if (idx_r == LAST_IDX) begin
        // Last clear write: arbitration is live again while it is on the outputs
        clear_done_nx = 1'b1;
        idx_nx        = FIRST_IDX;
        state_nx      = ST_ARB;
      end else begin
        idx_nx   = idx_r + regnum'(1);
        state_nx = ST_CLEAR;
      end
    end else begin
      idx_nx = idx_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r        <= ST_ARB;
      idx_r          <= FIRST_IDX;
      write_r        <= word'(0);
      write_reg_r    <= regnum'(0);
      write_enable_r <= 1'b0;
      clear_busy_r   <= 1'b0;
      clear_done_r   <= 1'b0;
    end else begin
      state_r        <= state_nx;
      idx_r          <= idx_nx;
      write_r        <= write_nx;
      write_reg_r    <= write_reg_nx;
      write_enable_r <= write_enable_nx;
      clear_busy_r   <= clear_busy_nx;
      clear_done_r   <= clear_done_nx;
    end
  end

  assign write        = write_r;
  assign write_reg    = write_reg_r;
  assign write_enable = write_enable_r;
  assign clear_busy   = clear_busy_r;
  assign clear_done   = clear_done_r;

endmodule
